ctl_round: RTL

Game-flow controller for Duck Hunt. Sequences a game as rounds of `DUCKS_PER_ROUND` ducks: launches each duck via `game_start` to `ctl_duck`, counts hits and escapes, decides round pass/fail and game over, and drives the `pause`/`looser` overlay flags and the `reset_score` pulse to `ctl_score`/`ctl_ammo`. Sits in the ctrl section beside `ctl_duck`, consuming its `duck_hit`/escape events and `no_ammo` from `ctl_ammo`, and replacing the direct `test_btn`/switch hookups.

---
 rtl/dh_game_pkg.sv | 48 ++++
 rtl/ctl_round_if.sv | 27 ++
 rtl/frame_timer.sv | 42 ++++
 rtl/ctl_round.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dh_game_pkg.sv
// Duck Hunt game-flow types and defaults shared by ctl_round, its timer and its bus.
//   state_t  : game-flow state, 3-bit encoding IDLE=0 .. GAME_OVER=6
//   status_t : registered status payload that ctl_round presents on its bus
package dh_game_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMR_W = 8;

  localparam int unsigned DEF_DUCKS_PER_ROUND = 10;
  localparam int unsigned DEF_PASS_HITS       = 6;
  localparam int unsigned DEF_ROUNDS_MAX      = 9;
  localparam int unsigned DEF_INTRO_FRAMES    = 120;
  localparam int unsigned DEF_GAP_FRAMES      = 60;
  localparam int unsigned DEF_END_FRAMES      = 180;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INTRO     = 3'd1,
    LAUNCH    = 3'd2,
    FLY       = 3'd3,
    GAP       = 3'd4,
    ROUND_END = 3'd5,
    GAME_OVER = 3'd6
  } state_t;

  typedef struct packed {
    logic             game_start;
    logic             reset_score;
    logic             pause;
    logic             looser;
    logic [CNT_W-1:0] round_num;
    logic [CNT_W-1:0] hits_in_round;
    logic [CNT_W-1:0] ducks_left;
    state_t           game_state;
  } status_t;

  // Increment that sticks at lim.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lim);
    return (v >= lim) ? v : v + CNT_W'(1);
  endfunction

  // Decrement that sticks at zero.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

endpackage

// File: rtl/ctl_round_if.sv
// Bus between ctl_round and the rest of the ctrl section.
//   inputs to ctl_round : new_frame, start_btn, pause_req, duck_hit, duck_escaped, no_ammo
//   outputs of ctl_round: status (game_start, reset_score, pause, looser, round_num,
//                         hits_in_round, ducks_left, game_state)
// slave is the controller side, master is the environment side.
interface ctl_round_if;
  import dh_game_pkg::*;

  logic    new_frame;
  logic    start_btn;
  logic    pause_req;
  logic    duck_hit;
  logic    duck_escaped;
  logic    no_ammo;
  status_t status;

  modport slave (
    input  new_frame, start_btn, pause_req, duck_hit, duck_escaped, no_ammo,
    output status
  );

  modport master (
    output new_frame, start_btn, pause_req, duck_hit, duck_escaped, no_ammo,
    input  status
  );

endinterface

// File: rtl/frame_timer.sv
// Frame down-counter shared by the timed game states.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : load load_val_i (wins over en_i)
//   load_val_i  : frames minus one
//   en_i        : one counted frame
//   done_c      : combinational, high on the counted frame seen at count zero
module frame_timer
  import dh_game_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Count down and rest at zero; the owner reloads on every timed-state entry.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  assign done_c = en_i && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ctl_round.sv
// Duck Hunt game-flow controller: sequences rounds of ducks, counts hits/escapes,
// decides round pass/fail and game over, drives pause/looser overlay flags and
// the reset_score pulse.
//   clk  : system clock
//   rst  : async active-low reset
//   bus  : ctl_round_if.slave (frame/button/duck events in, registered status out)
module ctl_round
  import dh_game_pkg::*;
#(
  parameter int unsigned DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
  parameter int unsigned PASS_HITS       = DEF_PASS_HITS,
  parameter int unsigned ROUNDS_MAX      = DEF_ROUNDS_MAX,
  parameter int unsigned INTRO_FRAMES    = DEF_INTRO_FRAMES,
  parameter int unsigned GAP_FRAMES      = DEF_GAP_FRAMES,
  parameter int unsigned END_FRAMES      = DEF_END_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  ctl_round_if.slave  bus
);

  localparam logic [CNT_W-1:0] DUCKS_C  = CNT_W'(DUCKS_PER_ROUND);
  localparam logic [CNT_W-1:0] PASS_C   = CNT_W'(PASS_HITS);
  localparam logic [CNT_W-1:0] ROUNDS_C = CNT_W'(ROUNDS_MAX);
  localparam logic [TMR_W-1:0] INTRO_LD = TMR_W'(INTRO_FRAMES - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_FRAMES - 1);
  localparam logic [TMR_W-1:0] END_LD   = TMR_W'(END_FRAMES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             looser_q, looser_d;
  logic             pause_q, pause_d;
  logic             game_start_q, game_start_d;
  logic             reset_score_q, reset_score_d;

  logic             tmr_load_c;
  logic [TMR_W-1:0] tmr_val_c;
  logic             tmr_done_c;
  logic             pause_live_c;

  // Pause only has effect while a game is in progress; it freezes frame counting.
  assign pause_live_c = bus.pause_req && !(state_q inside {IDLE, GAME_OVER});

  frame_timer #(.W(TMR_W)) u_frame_timer (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (tmr_load_c),
    .load_val_i (tmr_val_c),
    .en_i       (bus.new_frame && !pause_live_c),
    .done_c     (tmr_done_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    hits_d        = hits_q;
    left_d        = left_q;
    looser_d      = looser_q;
    game_start_d  = 1'b0;
    reset_score_d = 1'b0;
    tmr_load_c    = 1'b0;
    tmr_val_c     = '0;

    case (state_q)
      IDLE, GAME_OVER: begin
        if (bus.start_btn) begin
          state_d       = INTRO;
          round_d       = CNT_W'(1);
          hits_d        = '0;
          left_d        = DUCKS_C;
          looser_d      = 1'b0;
          reset_score_d = 1'b1;
          tmr_load_c    = 1'b1;
          tmr_val_c     = INTRO_LD;
        end
      end

      INTRO: begin
        // Timer cannot fire while paused, so LAUNCH is held off for free.
        if (tmr_done_c) begin
          state_d      = LAUNCH;
          game_start_d = 1'b1;
          left_d       = sat_dec(left_q);
        end
      end

      LAUNCH: begin
        state_d = FLY;
      end

      FLY: begin
        // A hit outranks an escape or running dry in the same cycle.
        if (bus.duck_hit) begin
          hits_d     = sat_inc(hits_q, DUCKS_C);
          state_d    = GAP;
          tmr_load_c = 1'b1;
          tmr_val_c  = GAP_LD;
        end else if (bus.duck_escaped) begin
          state_d    = GAP;
          tmr_load_c = 1'b1;
          tmr_val_c  = GAP_LD;
        end else if (bus.no_ammo) begin
          state_d  = GAME_OVER;
          looser_d = 1'b1;
        end
      end

      GAP: begin
        if (tmr_done_c) begin
          if (left_q != '0) begin
            state_d      = LAUNCH;
            game_start_d = 1'b1;
            left_d       = sat_dec(left_q);
          end else begin
            state_d    = ROUND_END;
            tmr_load_c = 1'b1;
            tmr_val_c  = END_LD;
          end
        end
      end

      ROUND_END: begin
        if (tmr_done_c) begin
          if (hits_q < PASS_C) begin
            state_d  = GAME_OVER;
            looser_d = 1'b1;
          end else if (round_q == ROUNDS_C) begin
            state_d  = GAME_OVER;
            looser_d = 1'b0;
          end else begin
            state_d    = INTRO;
            round_d    = round_q + CNT_W'(1);
            hits_d     = '0;
            left_d     = DUCKS_C;
            tmr_load_c = 1'b1;
            tmr_val_c  = INTRO_LD;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered pause flag tracks the state being entered.
    pause_d = bus.pause_req && !(state_d inside {IDLE, GAME_OVER});
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      round_q       <= '0;
      hits_q        <= '0;
      left_q        <= '0;
      looser_q      <= 1'b0;
      pause_q       <= 1'b0;
      game_start_q  <= 1'b0;
      reset_score_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      hits_q        <= hits_d;
      left_q        <= left_d;
      looser_q      <= looser_d;
      pause_q       <= pause_d;
      game_start_q  <= game_start_d;
      reset_score_q <= reset_score_d;
    end
  end

  assign bus.status = '{
    game_start:    game_start_q,
    reset_score:   reset_score_q,
    pause:         pause_q,
    looser:        looser_q,
    round_num:     round_q,
    hits_in_round: hits_q,
    ducks_left:    left_q,
    game_state:    state_q
  };

endmodule
